// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEMWAIT/WB control FSM that owns the shared memory port.
// Optional feature macro: SEQ_PERF_CNT_EN builds the instruction/cycle performance counters.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_halt_op,
    input  logic             i_needs_mem,
    input  logic             i_is_store,
    input  logic             i_needs_wb,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_mem_sel,
    output logic             o_mem_we,
    output logic             o_ir_load,
    output logic             o_pc_inc,
    output logic             o_decode_en,
    output logic             o_exec_en,
    output logic             o_wb_en,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_instr_count,
    output logic [CNT_W-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEMWAIT = 3'd4,
        S_WB      = 3'd5,
        S_HALTED  = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_tmo;
    logic       r_needs_mem;
    logic       r_is_store;
    logic       r_needs_wb;
    logic       r_mem_req;
    logic       r_mem_sel;
    logic       r_mem_we;
    logic       r_decode_en;
    logic       r_exec_en;
    logic       r_wb_en;
    logic       r_halted;
    logic       r_fault;
    logic       w_tmo_hit;
    logic       w_waiting;
    logic       w_enter_wait;

    assign w_tmo_hit    = (r_tmo == 8'(MEM_TIMEOUT - 1));
    assign w_waiting    = (r_state == S_FETCH) || (r_state == S_MEMWAIT);
    assign w_enter_wait = (w_next != r_state) &&
                          ((w_next == S_FETCH) || (w_next == S_MEMWAIT));

    // An ack on the last allowed wait cycle is checked before the timeout.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_FETCH;
            S_FETCH: begin
                if (i_mem_ack)      w_next = S_DECODE;
                else if (w_tmo_hit) w_next = S_FAULT;
            end
            S_DECODE:  w_next = i_halt_op ? S_HALTED : S_EXEC;
            S_EXEC: begin
                if (r_needs_mem)     w_next = S_MEMWAIT;
                else if (r_needs_wb) w_next = S_WB;
                else                 w_next = S_FETCH;
            end
            S_MEMWAIT: begin
                if (i_mem_ack)      w_next = r_needs_wb ? S_WB : S_FETCH;
                else if (w_tmo_hit) w_next = S_FAULT;
            end
            S_WB:      w_next = S_FETCH;
            default:   w_next = r_state;
        endcase
    end

    // Moore outputs are registered from the next state so they change with r_state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tmo       <= '0;
            r_needs_mem <= 1'b0;
            r_is_store  <= 1'b0;
            r_needs_wb  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_decode_en <= 1'b0;
            r_exec_en   <= 1'b0;
            r_wb_en     <= 1'b0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_needs_mem <= i_needs_mem;
                r_is_store  <= i_is_store;
                r_needs_wb  <= i_needs_wb;
            end
            if (w_enter_wait)
                r_tmo <= '0;
            else if (w_waiting && !i_mem_ack)
                r_tmo <= r_tmo + 8'd1;
            r_mem_req   <= (w_next == S_FETCH) || (w_next == S_MEMWAIT);
            r_mem_sel   <= (w_next == S_MEMWAIT);
            r_mem_we    <= (w_next == S_MEMWAIT) && r_is_store;
            r_decode_en <= (w_next == S_DECODE);
            r_exec_en   <= (w_next == S_EXEC);
            r_wb_en     <= (w_next == S_WB);
            r_halted    <= (w_next == S_HALTED);
            r_fault     <= (w_next == S_FAULT);
        end
    end

    assign o_state     = r_state;
    assign o_mem_req   = r_mem_req;
    assign o_mem_sel   = r_mem_sel;
    assign o_mem_we    = r_mem_we;
    assign o_decode_en = r_decode_en;
    assign o_exec_en   = r_exec_en;
    assign o_wb_en     = r_wb_en;
    assign o_halted    = r_halted;
    assign o_fault     = r_fault;
    assign o_ir_load   = (r_state == S_FETCH) && i_mem_ack;
    assign o_pc_inc    = (r_state == S_FETCH) && i_mem_ack;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_instr_count;
    logic [CNT_W-1:0] r_cycle_count;
    logic             w_retire;
    logic             w_active;

    assign w_retire = ((w_next == S_FETCH) && (r_state inside {S_EXEC, S_MEMWAIT, S_WB})) ||
                      ((w_next == S_HALTED) && (r_state == S_DECODE));
    assign w_active = r_state inside {S_FETCH, S_DECODE, S_EXEC, S_MEMWAIT, S_WB};

    // Both counters saturate at all-ones instead of wrapping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            if (w_retire && (r_instr_count != '1))
                r_instr_count <= r_instr_count + 1'b1;
            if (w_active && (r_cycle_count != '1))
                r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign o_instr_count = r_instr_count;
    assign o_cycle_count = r_cycle_count;
`else
    assign o_instr_count = '0;
    assign o_cycle_count = '0;
`endif

endmodule
